uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DEPTH, 16, RX FIFO entries in FIFO mode (power of two).
REQ-002 Parameter TO_TICKS, 640, baud_pulse ticks for character timeout (4 chars x 10 bits x 16).
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 baud_pulse  in  1  16x bit-rate tick, one clk wide.
REQ-006 rx_push  in  1  one-cycle strobe: received character valid on rx_din/rx_pe/rx_fe/rx_bi.
REQ-007 rx_din  in  8  received character.
REQ-008 rx_pe, rx_fe, rx_bi  in  1 each  parity, framing and break flags of the pushed character.
REQ-009 rd  in  1  one-cycle host read strobe, pops the head entry.
REQ-010 lsr_rd  in  1  one-cycle host line-status read strobe.
REQ-011 fifo_en  in  1  1 = FIFO mode (DEPTH entries), 0 = single holding register.
REQ-012 fifo_clr  in  1  one-cycle FIFO flush strobe.
REQ-013 trig_lvl  in  2  RX trigger level: 00=1, 01=4, 10=8, 11=14 entries.
REQ-014 erbi, elsi  in  1 each  data-available and line-status interrupt enables.
REQ-015 rx_dout  out  8  head entry data, 8'h00 when empty.
REQ-016 rx_count  out  5  entries held, 0..DEPTH.
REQ-017 dr, oe, pe_err, fe_err, bi_err, fifo_err  out  1 each  line status bits.
REQ-018 rda_irq, to_irq, ls_irq  out  1 each  interrupt requests.

Function
REQ-019 Each entry stores {bi,fe,pe,data} (11 bits); rx_dout and head flags are show-ahead from read pointer.
REQ-020 Effective capacity is DEPTH when fifo_en=1, 1 when fifo_en=0; full = (rx_count == capacity).
REQ-021 rx_push with not full: write at write pointer, pointer wraps modulo DEPTH, rx_count+1 next cycle.
REQ-022 rx_push while full and no rd: character discarded, contents unchanged, oe set.
REQ-023 rd while non-empty: read pointer advances with wrap, rx_count-1; rd while empty: ignored, no state change.
REQ-024 Simultaneous rx_push and rd: both performed, rx_count unchanged, no overrun even when full.
REQ-025 dr = (rx_count != 0), combinational.
REQ-026 pe_err/fe_err/bi_err sticky: set in the cycle after a flagged entry becomes head (push into empty or pointer advance); cleared by lsr_rd; set wins over same-cycle lsr_rd.
REQ-027 oe sticky: cleared by lsr_rd; same-cycle overrun wins.
REQ-028 Flag counter tracks entries with any of pe/fe/bi set (+1 on flagged push, -1 on flagged pop); fifo_err = fifo_en & (counter != 0).
REQ-029 Timeout FSM states: TO_IDLE, TO_COUNT, TO_FIRED; only active when fifo_en=1.
REQ-030 TO_IDLE -> TO_COUNT when rx_count != 0; tick counter cleared.
REQ-031 TO_COUNT: counter +1 per baud_pulse; cleared on rx_push or rd; -> TO_FIRED when counter reaches TO_TICKS-1 on a baud_pulse; -> TO_IDLE if FIFO becomes empty.
REQ-032 TO_FIRED -> TO_COUNT (counter cleared) on rx_push or rd with FIFO still non-empty, -> TO_IDLE if FIFO becomes empty.
REQ-033 rda_irq = erbi & (fifo_en ? rx_count >= trigger : dr); to_irq = erbi & (state == TO_FIRED).
REQ-034 ls_irq = elsi & (oe | pe_err | fe_err | bi_err).
REQ-035 fifo_clr, or any change of fifo_en (registered compare), empties FIFO: pointers, rx_count, flag counter to 0, timeout FSM to TO_IDLE; sticky status bits unaffected; same-cycle rx_push discarded.

Reset
REQ-036 rst low asynchronously clears pointers, rx_count, flag counter, tick counter, all sticky bits, and forces TO_IDLE; all outputs 0, rx_dout 8'h00.
REQ-037 rst asserted mid-character or mid-timeout abandons the operation; no push or status survives reset.

Verification
REQ-038 fifo_en=1, trig_lvl=01, push 8'h41..8'h44 -> rda_irq rises after 4th push; four rd return 41,42,43,44; dr=0 after.
REQ-039 fifo_en=1, push 17 chars without rd -> rx_count=16, oe=1, ls_irq=1 (elsi=1); 17th char absent; lsr_rd clears oe.
REQ-040 Push 8'h55 with rx_pe=1 behind 8'h10 -> pe_err=0, fifo_err=1; rd -> pe_err=1 next cycle; rd again -> fifo_err=0.
REQ-041 fifo_en=1, trig_lvl=11, push 2 chars, 639 baud_pulses -> to_irq=0; 640th -> to_irq=1; one rd -> to_irq=0.
REQ-042 fifo_en=0, push 8'hA5 then 8'h5A -> rx_dout=A5, oe=1; same-cycle push+rd when full -> rx_count stays 1, oe unchanged.
REQ-043 Three entries held, rst low one cycle -> rx_count=0, dr=0, all status/irq 0, rx_dout=8'h00.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive buffer controller: stores received characters with their
// parity/framing/break flags in a FIFO (or a single holding register),
// maintains the sticky line-status bits and raises the data-available,
// character-timeout and line-status interrupt requests.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   baud_pulse         16x bit-rate tick (one clk wide)
//   rx_push, rx_din,
//   rx_pe/fe/bi        received character strobe, data and error flags
//   rd, lsr_rd         host data read / line-status read strobes
//   fifo_en, fifo_clr  FIFO mode select / flush strobe
//   trig_lvl           RX trigger level select (1/4/8/14 entries)
//   erbi, elsi         data-available / line-status interrupt enables
//   rx_dout, rx_count  head data (show-ahead) and occupancy
//   dr, oe, pe_err, fe_err, bi_err, fifo_err   line status
//   rda_irq, to_irq, ls_irq                    interrupt requests
module uart_rx_ctrl #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TO_TICKS = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx_push,
  input  logic [7:0] rx_din,
  input  logic       rx_pe,
  input  logic       rx_fe,
  input  logic       rx_bi,
  input  logic       rd,
  input  logic       lsr_rd,
  input  logic       fifo_en,
  input  logic       fifo_clr,
  input  logic [1:0] trig_lvl,
  input  logic       erbi,
  input  logic       elsi,
  output logic [7:0] rx_dout,
  output logic [4:0] rx_count,
  output logic       dr,
  output logic       oe,
  output logic       pe_err,
  output logic       fe_err,
  output logic       bi_err,
  output logic       fifo_err,
  output logic       rda_irq,
  output logic       to_irq,
  output logic       ls_irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TO_TICKS);

  typedef enum logic [1:0] {TO_IDLE, TO_COUNT, TO_FIRED} to_state_e;

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rptr_nx;
  logic [4:0]    count_q, count_d, flagcnt_q, flagcnt_d, cap, trig;
  logic [2:0]    err_q, err_d, nh_flags, push_flags;
  logic          oe_q, oe_d, fifo_en_q;
  logic [TW-1:0] tick_q, tick_d;
  to_state_e     state_q, state_d;
  logic          empty, full, flush, do_rd, do_push, overrun, head_flagged;
  logic [10:0]   head;

  assign cap        = fifo_en ? 5'(DEPTH) : 5'd1;
  assign empty      = (count_q == '0);
  assign full       = (count_q >= cap);
  assign flush      = fifo_clr | (fifo_en ^ fifo_en_q);
  assign do_rd      = rd & ~empty & ~flush;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign do_push    = rx_push & (~full | do_rd) & ~flush;
  assign overrun    = rx_push & full & ~do_rd & ~flush;
  assign push_flags = {rx_bi, rx_fe, rx_pe};
  assign head       = mem_q[rptr_q];
  assign head_flagged = |head[10:8];
  assign rptr_nx    = rptr_q + AW'(1);

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    flagcnt_d = flagcnt_q;
    nh_flags  = '0;
    if (flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      flagcnt_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_rd)   rptr_d = rptr_nx;
      if (do_push && !do_rd)      count_d = count_q + 5'd1;
      else if (do_rd && !do_push) count_d = count_q - 5'd1;
      flagcnt_d = flagcnt_q + 5'(do_push & (|push_flags)) - 5'(do_rd & head_flagged);
      // Flags of whichever entry becomes head this cycle. When the last
      // entry is popped while a new one is pushed, the new head is the
      // incoming character, which is not in the array yet.
      if (do_rd) begin
        if (count_q != 5'd1)  nh_flags = mem_q[rptr_nx][10:8];
        else if (do_push)     nh_flags = push_flags;
      end else if (do_push && empty) begin
        nh_flags = push_flags;
      end
    end
    err_d = nh_flags | (err_q & ~{3{lsr_rd}});
    oe_d  = overrun | (oe_q & ~lsr_rd);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    if (flush || !fifo_en) begin
      state_d = TO_IDLE;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        TO_IDLE: begin
          if (!empty) begin
            state_d = TO_COUNT;
            tick_d  = '0;
          end
        end
        TO_COUNT: begin
          if (count_d == '0) begin
            state_d = TO_IDLE;
            tick_d  = '0;
          end else if (rx_push || rd) begin
            tick_d = '0;
          end else if (baud_pulse) begin
            if (tick_q == TW'(TO_TICKS - 1)) state_d = TO_FIRED;
            else                             tick_d  = tick_q + TW'(1);
          end
        end
        TO_FIRED: begin
          if (count_d == '0) begin
            state_d = TO_IDLE;
            tick_d  = '0;
          end else if (rx_push || rd) begin
            state_d = TO_COUNT;
            tick_d  = '0;
          end
        end
        default: begin
          state_d = TO_IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      flagcnt_q <= '0;
      err_q     <= '0;
      oe_q      <= 1'b0;
      fifo_en_q <= 1'b0;
      tick_q    <= '0;
      state_q   <= TO_IDLE;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      flagcnt_q <= flagcnt_d;
      err_q     <= err_d;
      oe_q      <= oe_d;
      fifo_en_q <= fifo_en;
      tick_q    <= tick_d;
      state_q   <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= {push_flags, rx_din};
  end

  always_comb begin
    unique case (trig_lvl)
      2'b00:   trig = 5'd1;
      2'b01:   trig = 5'd4;
      2'b10:   trig = 5'd8;
      default: trig = 5'd14;
    endcase
  end

  assign rx_count = count_q;
  assign dr       = ~empty;
  assign rx_dout  = empty ? 8'h00 : head[7:0];
  assign oe       = oe_q;
  assign pe_err   = err_q[0];
  assign fe_err   = err_q[1];
  assign bi_err   = err_q[2];
  assign fifo_err = fifo_en & (flagcnt_q != '0);
  assign rda_irq  = erbi & (fifo_en ? (count_q >= trig) : dr);
  assign to_irq   = erbi & (state_q == TO_FIRED);
  assign ls_irq   = elsi & (oe_q | (|err_q));

endmodule
